arb_rr3_lock: RTL and testbench
===============================

Name: arb_rr3_lock

Overview:
3-requester round-robin arbiter with a registered req/ack handshake toward one shared downstream resource. A winner is locked in until it releases its request, so the resource serves one requester per transaction. It replaces combinational static-priority arbitration wherever fairness and glitch-free registered acknowledges are required. Upstream requesters attach on the req_i/ack_i side; the resource attaches on req_o/ack_o.

Parameters:
MAX_HOLD, 16, max cycles a grant may stay in GRANT (used only with ARB_TIMEOUT_EN); legal range 1..255
CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
req_i  input  3  per-requester request, level, held until the transaction completes
ack_i  output  3  per-requester acknowledge, one-hot or zero, registered
req_o  output  1  request to the shared resource, registered
ack_o  input  1  resource acknowledge, level
owner_o  output  2  encoded current owner 0..2; 3 = none; registered

Behaviour:
- Reset (rstn=0, async): state=IDLE, ack_i=0, req_o=0, owner_o=3, last=2 (requester 0 has top priority first), hold counter=0.
- States: IDLE, REQ, GRANT. All outputs are decoded from registered state; no combinational path from any input to any output.
- IDLE: if req_i!=0, pick the winner by rotating priority last+1, last+2, last (mod 3). Next cycle: owner_o=winner, req_o=1, state=REQ. If req_i==0, stay in IDLE.
- REQ: req_o=1, ack_i=0.
  - ack_o=1 and req_i[owner]=1: next cycle ack_i=onehot(owner), state=GRANT, counter cleared.
  - req_i[owner]=0 (abandon; takes priority over ack_o): next cycle state=IDLE, req_o=0, owner_o=3, last unchanged.
- GRANT: req_o=1, ack_i=onehot(owner). ack_o is ignored in this state.
  - req_i[owner]=0: next cycle ack_i=0, req_o=0, owner_o=3, last=owner, state=IDLE.
- Latency: with ack_o tied high, req_i asserted before edge n gives req_o after edge n and ack_i after edge n+1. Release takes 1 cycle.
- Requests from other requesters during REQ or GRANT are ignored; they are re-evaluated in IDLE. At least one IDLE cycle separates consecutive grants.
- Simultaneous requests in IDLE resolve strictly by the rotating order. A requester that is alone re-wins immediately after its own release.
- Invariants: ack_i is never multi-hot; ack_i!=0 implies req_o=1; owner_o=3 exactly when state=IDLE.
- Asserting rstn mid-transaction returns to reset values immediately. A requester must not treat a dropped ack_i as completion.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined: the hold counter increments each GRANT cycle. When counter==MAX_HOLD-1 and req_i[owner] is still 1, the next cycle forces the release sequence (ack_i=0, req_o=0, owner_o=3, last=owner, IDLE). This is a preemption; the owner may re-request and is arbitrated normally.
- Undefined: the counter and its logic are absent, and GRANT lasts until req_i[owner] falls.

Test Plan:
- Reset, then req_i=3'b111 with ack_o=1: owners granted in order 0,1,2,0. Each ack_i asserts 2 cycles after entering IDLE; each requester holds req 3 cycles after its ack.
- req_i=3'b010 with ack_o=0 for 5 cycles: req_o=1, owner_o=1, ack_i=0 throughout. Raise ack_o: ack_i=3'b010 on the next cycle.
- Abandon: req_i=3'b100, ack_o=0; drop req_i[2] in REQ: IDLE next cycle, owner_o=3. Then req_i=3'b101: requester 0 wins because last is still 2.
- Lock: requester 1 in GRANT; assert req_i[0] and req_i[2]: ack_i stays 3'b010 until req_i[1] falls. Then requester 2 wins.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req_i=3'b011 held: ack_i=3'b001 for exactly 4 cycles, then 0, then requester 1 granted.
- Assert rstn low while in GRANT: ack_i=0, req_o=0, owner_o=3 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/arb_rr3_lock_if.sv
// Handshake bundle between three upstream requesters, the arbiter and the shared resource.
// master: arbiter view. slave: environment view (requesters + resource).
interface arb_rr3_lock_if;
    logic [2:0] req_i;
    logic [2:0] ack_i;
    logic       req_o;
    logic       ack_o;
    logic [1:0] owner_o;

    modport master (
        input  req_i,
        input  ack_o,
        output ack_i,
        output req_o,
        output owner_o
    );

    modport slave (
        output req_i,
        output ack_o,
        input  ack_i,
        input  req_o,
        input  owner_o
    );
endinterface

// File: rtl/arb_rr3_lock.sv
// arb_rr3_lock: 3-requester round-robin arbiter with a locked, registered
// req/ack handshake toward one shared resource.
// Optional macro ARB_TIMEOUT_EN: bounds a grant to MAX_HOLD cycles and then
// preempts the owner. Without it the hold counter is not built.
module arb_rr3_lock #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic           clk,
    input  logic           rstn,
    arb_rr3_lock_if.master bus
);

    localparam int unsigned OWN_W = 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_GRANT = 2'd2;

    localparam logic [OWN_W-1:0] OWNER_NONE = OWN_W'(3);

    // Reject configurations whose counter cannot reach MAX_HOLD-1.
    if (MAX_HOLD < 1 || MAX_HOLD > 255 || (MAX_HOLD >> CNT_W) != 0) begin : g_bad_cfg
        $error("arb_rr3_lock: illegal MAX_HOLD/CNT_W combination");
    end

    logic [1:0]       state_q, state_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [OWN_W-1:0] last_q,  last_d;

    logic [2:0]       ack_q,   ack_d;
    logic             req_q,   req_d;
    logic [OWN_W-1:0] own_q,   own_d;

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Rotating priority: search starts one past the last served requester.
    function automatic logic [OWN_W-1:0] pick_winner(input logic [OWN_W-1:0] last,
                                                     input logic [2:0]       req);
        logic [OWN_W-1:0] w;
        w = OWN_W'(0);
        case (last)
            OWN_W'(0): w = req[1] ? OWN_W'(1) : (req[2] ? OWN_W'(2) : OWN_W'(0));
            OWN_W'(1): w = req[2] ? OWN_W'(2) : (req[0] ? OWN_W'(0) : OWN_W'(1));
            default:   w = req[0] ? OWN_W'(0) : (req[1] ? OWN_W'(1) : OWN_W'(2));
        endcase
        return w;
    endfunction

    // Next-state, winner selection and next output values.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req_i != 3'b000) begin
                    owner_d = pick_winner(last_q, bus.req_i);
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!bus.req_i[owner_q]) begin
                    state_d = S_IDLE;
                end else if (bus.ack_o) begin
                    state_d = S_GRANT;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = CNT_W'(0);
`endif
                end
            end
            S_GRANT: begin
                if (!bus.req_i[owner_q]) begin
                    state_d = S_IDLE;
                    last_d  = owner_q;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                    last_d  = owner_q;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_d = (state_d != S_IDLE);
        own_d = (state_d == S_IDLE) ? OWNER_NONE : owner_d;
        ack_d = (state_d == S_GRANT) ? 3'(3'b001 << owner_d) : 3'b000;
    end

    // State, arbitration history and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            owner_q <= OWN_W'(0);
            last_q  <= OWN_W'(2);
            ack_q   <= 3'b000;
            req_q   <= 1'b0;
            own_q   <= OWNER_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            req_q   <= req_d;
            own_q   <= own_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Grant hold counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= CNT_W'(0);
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.ack_i   = ack_q;
    assign bus.req_o   = req_q;
    assign bus.owner_o = own_q;

endmodule

// File: tb/tb_arb_rr3_lock.sv
// Bench for arb_rr3_lock: directed vectors with literal expectations plus a
// cycle-level behavioural model compared every cycle out of reset.
module tb_arb_rr3_lock;

    localparam int unsigned TB_MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    arb_rr3_lock_if bus ();

    arb_rr3_lock #(.MAX_HOLD(TB_MAX_HOLD), .CNT_W(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // phase: 0 = idle, 1 = requesting resource, 2 = granted
    int m_phase = 0;
    int m_owner = 0;
    int m_last  = 2;
    int m_held  = 0;
    bit timeout_on;

    initial begin
`ifdef ARB_TIMEOUT_EN
        timeout_on = 1'b1;
`else
        timeout_on = 1'b0;
`endif
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_phase = 0;
            m_last  = 2;
            m_held  = 0;
        end else begin
            case (m_phase)
                0: begin
                    for (int k = 1; k <= 3; k++) begin
                        int cand;
                        cand = (m_last + k) % 3;
                        if (m_phase == 0 && bus.req_i[cand]) begin
                            m_owner = cand;
                            m_phase = 1;
                        end
                    end
                end
                1: begin
                    if (!bus.req_i[m_owner]) m_phase = 0;
                    else if (bus.ack_o) begin
                        m_phase = 2;
                        m_held  = 0;
                    end
                end
                default: begin
                    m_held = m_held + 1;
                    if (!bus.req_i[m_owner] || (timeout_on && m_held == TB_MAX_HOLD)) begin
                        m_phase = 0;
                        m_last  = m_owner;
                    end
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model plus structural invariants.
    always @(posedge clk) begin
        #1;
        if (rstn) begin
            chk("model_req_o", 32'(bus.req_o), (m_phase != 0) ? 32'd1 : 32'd0);
            chk("model_owner_o", 32'(bus.owner_o), (m_phase == 0) ? 32'd3 : 32'(m_owner));
            chk("model_ack_i", 32'(bus.ack_i), (m_phase == 2) ? (32'd1 << m_owner) : 32'd0);
            chk("inv_onehot0", 32'($onehot0(bus.ack_i)), 32'd1);
            chk("inv_ack_req", 32'((bus.ack_i == 3'b000) || bus.req_o), 32'd1);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        #3 rstn = 1'b1;
        tick();
    endtask

    // Wait (bounded) for any ack; returns cycles waited.
    task automatic wait_ack(input string name, output int cycles);
        cycles = 0;
        while (bus.ack_i == 3'b000 && cycles < 20) begin
            tick();
            cycles++;
        end
        if (bus.ack_i == 3'b000) begin
            errors++;
            checks++;
            $display("FAIL %s: no ack within %0d cycles", name, cycles);
        end
    endtask

    initial begin
        int n;
        logic [2:0] order [4];
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;

        bus.req_i = 3'b000;
        bus.ack_o = 1'b0;
        #12;
        chk("reset_ack", 32'(bus.ack_i), 32'd0);
        chk("reset_req", 32'(bus.req_o), 32'd0);
        chk("reset_owner", 32'(bus.owner_o), 32'd3);
        rstn = 1'b1;
        tick();

        // Round robin with all three requesting.
        bus.ack_o = 1'b1;
        bus.req_i = 3'b111;
        for (int g = 0; g < 4; g++) begin
            wait_ack("rr_wait", n);
            chk("rr_latency", 32'(n), 32'd2);
            chk("rr_order", 32'(bus.ack_i), 32'(order[g]));
            tick();
            tick();
            bus.req_i = bus.req_i & ~order[g];
            tick();
            chk("rr_release_owner", 32'(bus.owner_o), 32'd3);
            chk("rr_release_ack", 32'(bus.ack_i), 32'd0);
            bus.req_i = (g == 3) ? 3'b000 : 3'b111;
        end
        tick();

        // Resource stalls the handshake.
        bus.ack_o = 1'b0;
        bus.req_i = 3'b010;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_req", 32'(bus.req_o), 32'd1);
            chk("stall_owner", 32'(bus.owner_o), 32'd1);
            chk("stall_ack", 32'(bus.ack_i), 32'd0);
        end
        bus.ack_o = 1'b1;
        tick();
        chk("stall_grant", 32'(bus.ack_i), 32'b010);
        bus.req_i = 3'b000;
        tick();

        // Abandon during REQ keeps the rotation pointer.
        do_reset();
        bus.ack_o = 1'b0;
        bus.req_i = 3'b100;
        tick();
        chk("abandon_owner_req", 32'(bus.owner_o), 32'd2);
        bus.req_i = 3'b000;
        tick();
        chk("abandon_idle", 32'(bus.owner_o), 32'd3);
        chk("abandon_req_o", 32'(bus.req_o), 32'd0);
        bus.req_i = 3'b101;
        bus.ack_o = 1'b1;
        tick();
        chk("abandon_winner", 32'(bus.owner_o), 32'd0);
        tick();
        chk("abandon_grant", 32'(bus.ack_i), 32'b001);
        bus.req_i = 3'b000;
        tick();

        // Lock: other requests ignored while requester 1 holds the grant.
        bus.req_i = 3'b010;
        tick();
        tick();
        chk("lock_grant", 32'(bus.ack_i), 32'b010);
        bus.req_i = 3'b111;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("lock_hold", 32'(bus.ack_i), 32'b010);
        end
        bus.req_i = 3'b101;
        tick();
        chk("lock_release", 32'(bus.owner_o), 32'd3);
        tick();
        chk("lock_next_owner", 32'(bus.owner_o), 32'd2);
        tick();
        chk("lock_next_ack", 32'(bus.ack_i), 32'b100);
        bus.req_i = 3'b000;
        tick();

        // Long hold: preempted after MAX_HOLD cycles only with the timeout built in.
        do_reset();
        bus.req_i = 3'b011;
        tick();
        tick();
        for (int c = 0; c < 4; c++) begin
            chk("hold_owner0", 32'(bus.ack_i), 32'b001);
            tick();
        end
        if (timeout_on) begin
            chk("timeout_drop", 32'(bus.ack_i), 32'd0);
            chk("timeout_owner", 32'(bus.owner_o), 32'd3);
            tick();
            chk("timeout_next", 32'(bus.owner_o), 32'd1);
            tick();
            chk("timeout_next_ack", 32'(bus.ack_i), 32'b010);
        end else begin
            for (int c = 0; c < 4; c++) begin
                chk("no_timeout_hold", 32'(bus.ack_i), 32'b001);
                tick();
            end
        end

        // Asynchronous reset in GRANT clears outputs without a clock edge.
        #2 rstn = 1'b0;
        #1;
        chk("async_ack", 32'(bus.ack_i), 32'd0);
        chk("async_req", 32'(bus.req_o), 32'd0);
        chk("async_owner", 32'(bus.owner_o), 32'd3);
        bus.req_i = 3'b000;
        #2 rstn = 1'b1;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
